dac_counter: RTL and testbench

//   Free-running ramp generator that produces the sample code for the game's audio DAC.
//   - While the upstream tick/enable `at_max` is high, the code advances one step per clock
//     (sawtooth).
//   - While `at_max` is low, the code is parked at zero.
//   - Sits between the audio prescaler (source of `at_max`) and the DAC output pins.

---
 rtl/dac_pkg.sv | 13 +
 rtl/dac_counter_if.sv | 23 ++
 rtl/dac_counter_next.sv | 41 ++++
 rtl/dac_counter.sv | 48 ++++
 tb/tb_dac_counter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/dac_pkg.sv
// Shared types and constants for the audio DAC ramp generator.
// The default code width and ramp top live here so the counter, its
// next-state logic and the bus interface agree on one definition.
package dac_pkg;

  localparam int DAC_WIDTH = 8;

  typedef logic [DAC_WIDTH-1:0] dac_code_t;

  // All-ones code: the natural top of the ramp at the default width.
  localparam dac_code_t DAC_MAX = '1;

endpackage : dac_pkg

// File: rtl/dac_counter_if.sv
// Bus between the audio prescaler and the DAC ramp generator.
// The prescaler side (master) drives the count enable at_max.
// The counter side (slave) returns the registered sample code dacCount.
interface dac_counter_if
  import dac_pkg::*;
#(
  parameter int WIDTH = DAC_WIDTH
);

  logic             at_max;
  logic [WIDTH-1:0] dacCount;

  modport master (
    output at_max,
    input  dacCount
  );

  modport slave (
    input  at_max,
    output dacCount
  );

endinterface : dac_counter_if

// File: rtl/dac_counter_next.sv
// Pure combinational next-count logic for the DAC ramp.
// The sum is formed one bit wider than the code so that the compare
// against the ramp top cannot be fooled by overflow. The result is
// truncated back to WIDTH only after that compare.
// Optional macro DAC_COUNTER_SATURATE_EN: when defined, the ramp sticks
// at MAX_COUNT instead of wrapping to zero.
module dac_counter_next
  import dac_pkg::*;
#(
  parameter int WIDTH     = DAC_WIDTH,
  parameter int MAX_COUNT = int'(DAC_MAX),
  parameter int STEP      = 1
) (
  input  logic [WIDTH-1:0] cur_count,
  input  logic             at_max,
  output logic [WIDTH-1:0] next_count
);

  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX_COUNT);

  logic [WIDTH:0] sum;

  // Advance by STEP while enabled, wrap or saturate past the top, park at zero when disabled.
  always_comb begin
    sum        = {1'b0, cur_count} + STEP_W;
    next_count = '0;
    if (at_max) begin
      if (sum <= MAX_W) begin
        next_count = sum[WIDTH-1:0];
      end else begin
`ifdef DAC_COUNTER_SATURATE_EN
        next_count = MAX_W[WIDTH-1:0];
`else
        next_count = '0;
`endif
      end
    end
  end

endmodule : dac_counter_next

// File: rtl/dac_counter.sv
// Free-running ramp generator producing the sample code for the audio DAC.
// While at_max is high the code climbs by STEP each clock (sawtooth);
// while it is low the code is parked at zero. The output is purely
// registered, so there is exactly one clock of latency from at_max.
// Optional macro DAC_COUNTER_SATURATE_EN: hold at MAX_COUNT instead of
// wrapping to zero once the ramp reaches the top.
module dac_counter
  import dac_pkg::*;
#(
  parameter int WIDTH     = DAC_WIDTH,
  parameter int MAX_COUNT = int'(DAC_MAX),
  parameter int STEP      = 1
) (
  input  logic          clk,
  input  logic          rst,
  dac_counter_if.slave  bus
);

  logic [WIDTH-1:0] next_count;

  // Reject parameter sets that would make the ramp top unreachable or the ramp stall.
  if (MAX_COUNT >= (1 << WIDTH)) begin : g_bad_max_count
    $error("dac_counter: MAX_COUNT must be below 2**WIDTH");
  end
  if (STEP < 1) begin : g_bad_step
    $error("dac_counter: STEP must be at least 1");
  end

  dac_counter_next #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT),
    .STEP      (STEP)
  ) u_next (
    .cur_count  (bus.dacCount),
    .at_max     (bus.at_max),
    .next_count (next_count)
  );

  // Sample register: reset has priority, otherwise take the computed next code.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dacCount <= '0;
    end else begin
      bus.dacCount <= next_count;
    end
  end

endmodule : dac_counter

// File: tb/tb_dac_counter.sv
// Directed bench for dac_counter.
// Two instances share clock and reset: a default one (8 bit, top 255,
// step 1) and a short-ramp one (step 3, top 10). Expected codes come from
// a small reference model and are queued as stimulus is applied, then
// popped and compared one time unit after the following rising edge.
module tb_dac_counter;
  import dac_pkg::*;

  logic tb_clk;
  logic tb_rst;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];

  int model_a = 0;
  int model_b = 0;

  dac_counter_if #(.WIDTH(8)) bus_a ();
  dac_counter_if #(.WIDTH(8)) bus_b ();

  dac_counter #(
    .WIDTH     (8),
    .MAX_COUNT (255),
    .STEP      (1)
  ) u_dut_a (
    .clk (tb_clk),
    .rst (tb_rst),
    .bus (bus_a)
  );

  dac_counter #(
    .WIDTH     (8),
    .MAX_COUNT (10),
    .STEP      (3)
  ) u_dut_b (
    .clk (tb_clk),
    .rst (tb_rst),
    .bus (bus_b)
  );

  // Free-running bench clock, 10 time units per period.
  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // Reference behaviour of the ramp register for one rising edge.
  function automatic int modelNext(int cur, bit r, bit en, int step, int max_count);
    if (r)   return 0;
    if (!en) return 0;
    if (cur + step > max_count) begin
`ifdef DAC_COUNTER_SATURATE_EN
      return max_count;
`else
      return 0;
`endif
    end
    return cur + step;
  endfunction

  task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Pop the oldest expectation for each instance and compare against the DUT.
  task automatic checkOutput();
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    if (exp_q_a.size() == 0 || exp_q_b.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=%0d expected=1", exp_q_a.size());
    end else begin
      exp_a = exp_q_a.pop_front();
      exp_b = exp_q_b.pop_front();
      checkValue("seq_a", bus_a.dacCount, exp_a);
      checkValue("seq_b", bus_b.dacCount, exp_b);
    end
  endtask

  // Drive one cycle of inputs, queue the modelled result, then check after the edge.
  task automatic applyStimulus(input bit r, input bit en_a, input bit en_b);
    @(negedge tb_clk);
    tb_rst       = r;
    bus_a.at_max = en_a;
    bus_b.at_max = en_b;
    model_a = modelNext(model_a, r, en_a, 1, 255);
    model_b = modelNext(model_b, r, en_b, 3, 10);
    exp_q_a.push_back(8'(model_a));
    exp_q_b.push_back(8'(model_b));
    @(posedge tb_clk);
    #1;
    checkOutput();
  endtask

  initial begin
    tb_rst       = 1'b1;
    bus_a.at_max = 1'b0;
    bus_b.at_max = 1'b0;
    $display("[TB] start");

    // Reset for two edges, then one idle edge with reset released.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkValue("reset_a", bus_a.dacCount, 8'd0);
    checkValue("reset_b", bus_b.dacCount, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkValue("post_reset", bus_a.dacCount, 8'd0);

    // Short ramp to 25, then drop the enable.
    for (int i = 0; i < 25; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkValue("ramp25", bus_a.dacCount, 8'd25);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkValue("clear_after_25", bus_a.dacCount, 8'd0);

    // Full ramp: 256 edges returns to zero, 300 edges lands on 44.
    for (int i = 0; i < 255; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkValue("top255", bus_a.dacCount, 8'd255);
    applyStimulus(1'b0, 1'b1, 1'b0);
`ifdef DAC_COUNTER_SATURATE_EN
    checkValue("edge256", bus_a.dacCount, 8'd255);
`else
    checkValue("edge256", bus_a.dacCount, 8'd0);
`endif
    for (int i = 0; i < 44; i++) applyStimulus(1'b0, 1'b1, 1'b0);
`ifdef DAC_COUNTER_SATURATE_EN
    checkValue("edge300", bus_a.dacCount, 8'd255);
`else
    checkValue("edge300", bus_a.dacCount, 8'd44);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkValue("clear_after_300", bus_a.dacCount, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkValue("resume_from_0", bus_a.dacCount, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Reset mid-ramp with the enable still high, then release.
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkValue("ramp100", bus_a.dacCount, 8'd100);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkValue("rst_mid_ramp", bus_a.dacCount, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkValue("restart_after_rst", bus_a.dacCount, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Short-ramp instance: step 3 up to a top of 10.
    checkValue("b_start", bus_b.dacCount, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkValue("b_step1", bus_b.dacCount, 8'd3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkValue("b_step2", bus_b.dacCount, 8'd6);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkValue("b_step3", bus_b.dacCount, 8'd9);
    applyStimulus(1'b0, 1'b0, 1'b1);
`ifdef DAC_COUNTER_SATURATE_EN
    checkValue("b_top", bus_b.dacCount, 8'd10);
`else
    checkValue("b_wrap", bus_b.dacCount, 8'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b1);
`ifdef DAC_COUNTER_SATURATE_EN
    checkValue("b_hold", bus_b.dacCount, 8'd10);
`else
    checkValue("b_after_wrap", bus_b.dacCount, 8'd3);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkValue("b_clear", bus_b.dacCount, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dac_counter
